toggle_arbiter: RTL and testbench

- Shares one downstream 2-phase (toggle) req/ack consumer, typically a sink or router input port, among N upstream 2-phase producers.
- Detects pending transfers per input and picks one by round-robin.
- Forwards the chosen input's data on a registered output channel, then completes the upstream handshake once the downstream acknowledges.
- Sits between source/router outputs and a single sink in the NoC testbench and router fabric.

---
 rtl/toggle_arbiter.sv | 94 +++++++++
 tb/tb_toggle_arbiter.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_arbiter.sv
// toggle_arbiter: round-robin arbiter that merges N two-phase (toggle) req/ack
// producers onto a single two-phase consumer with a registered output channel.
`default_nettype none

module toggle_arbiter #(
    parameter int ID   = 0,
    parameter int N    = 4,
    parameter int SIZE = 8,
    parameter int IW   = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N-1:0]      in_req,
    output logic [N-1:0]      in_ack,
    input  logic [N*SIZE-1:0] in_data,
    output logic              out_req,
    input  logic              out_ack,
    output logic [SIZE-1:0]   out_data,
    output logic [IW-1:0]     grant,
    output logic              busy
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

    state_t          state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   winner;
    logic            found;
    logic [N-1:0]    pending;

    assign pending = in_req ^ in_ack;

    // Index reached after stepping offs places past base, wrapping at N.
    function automatic logic [IW-1:0] rr_index(input logic [IW-1:0] base, input int offs);
        int s;
        s = int'(base) + offs;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    // Scan from the far end back toward ptr so the closest pending index wins.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pending[rr_index(ptr, k)]) begin
                winner = rr_index(ptr, k);
                found  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            in_ack   <= '0;
            out_req  <= 1'b0;
            out_data <= '0;
            grant    <= '0;
            busy     <= 1'b0;
            ptr      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant    <= winner;
                        out_data <= in_data[winner*SIZE +: SIZE];
                        out_req  <= ~out_req;
                        busy     <= 1'b1;
                        state    <= WAIT;
                    end
                end
                WAIT: begin
                    // Completing clears the served input's pending on this same edge.
                    if (out_ack == out_req) begin
                        in_ack[grant] <= ~in_ack[grant];
                        ptr           <= (grant == IW'(N - 1)) ? '0 : grant + 1'b1;
                        busy          <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_toggle_arbiter.sv
// tb_toggle_arbiter: directed, table-driven check of toggle_arbiter with a
// two-phase sink model of programmable acknowledge delay.
`default_nettype none

module tb_toggle_arbiter;

    localparam int N    = 4;
    localparam int SIZE = 8;
    localparam int IW   = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [N-1:0]      in_req;
    logic [N-1:0]      in_ack;
    logic [N*SIZE-1:0] in_data;
    logic              out_req;
    logic              out_ack = 1'b0;
    logic [SIZE-1:0]   out_data;
    logic [IW-1:0]     grant;
    logic              busy;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int sink_delay = 1;
    int sink_cnt   = 0;
    int log_grant[$];
    int log_data[$];
    int log_cyc[$];

    typedef struct {
        logic [N-1:0]     mask;
        logic [7:0]       base;
        int               n;
        logic [3:0][1:0]  ord;
    } vec_t;

    vec_t vecs[7];

    toggle_arbiter #(.ID(0), .N(N), .SIZE(SIZE), .IW(IW)) dut (
        .clk      (clk),
        .reset    (reset),
        .in_req   (in_req),
        .in_ack   (in_ack),
        .in_data  (in_data),
        .out_req  (out_req),
        .out_ack  (out_ack),
        .out_data (out_data),
        .grant    (grant),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Sink: logs each new word, acknowledges sink_delay negedges after first seeing it.
    always @(negedge clk) begin
        if (reset) begin
            out_ack  = 1'b0;
            sink_cnt = 0;
        end else if (out_req != out_ack) begin
            if (sink_cnt == 0) begin
                log_grant.push_back(int'(grant));
                log_data.push_back(int'(out_data));
                log_cyc.push_back(cyc);
            end
            if (sink_cnt >= sink_delay) begin
                out_ack  = ~out_ack;
                sink_cnt = 0;
            end else begin
                sink_cnt++;
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        in_req = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset      = 1'b0;
        sink_delay = 1;
        log_grant.delete();
        log_data.delete();
        log_cyc.delete();
    endtask

    task automatic run_vec(input int v);
        logic [N-1:0] exp_ack;
        bit           done;
        @(negedge clk);
        log_grant.delete();
        log_data.delete();
        log_cyc.delete();
        for (int i = 0; i < N; i++) begin
            if (vecs[v].mask[i]) in_data[i*SIZE +: SIZE] = vecs[v].base + 8'(i);
        end
        exp_ack = in_ack ^ vecs[v].mask;
        in_req  = in_req ^ vecs[v].mask;
        done = 1'b0;
        for (int c = 0; c < 60 && !done; c++) begin
            @(posedge clk);
            #1;
            if (in_ack == exp_ack && !busy) done = 1'b1;
        end
        chk($sformatf("vec%0d_done", v), 32'(done), 32'd1);
        chk($sformatf("vec%0d_count", v), 32'(log_grant.size()), 32'(vecs[v].n));
        chk($sformatf("vec%0d_in_ack", v), 32'(in_ack), 32'(exp_ack));
        for (int j = 0; j < vecs[v].n && j < log_grant.size(); j++) begin
            chk($sformatf("vec%0d_grant%0d", v, j), 32'(log_grant[j]), 32'(vecs[v].ord[j]));
            chk($sformatf("vec%0d_data%0d", v, j), 32'(log_data[j]),
                32'(vecs[v].base) + 32'(vecs[v].ord[j]));
            if (j > 0) begin
                chk($sformatf("vec%0d_gap%0d", v, j), 32'(log_cyc[j] - log_cyc[j-1]), 32'd3);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N-1:0] prev_ack;
        int           bad;
        int           toggles;

        vecs[0] = '{4'b1111, 8'h10, 4, {2'd3, 2'd2, 2'd1, 2'd0}};
        vecs[1] = '{4'b0110, 8'h20, 2, {2'd0, 2'd0, 2'd2, 2'd1}};
        vecs[2] = '{4'b0010, 8'h30, 1, {2'd0, 2'd0, 2'd0, 2'd1}};
        vecs[3] = '{4'b1001, 8'h40, 2, {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[4] = '{4'b0101, 8'h50, 2, {2'd0, 2'd0, 2'd0, 2'd2}};
        vecs[5] = '{4'b1000, 8'h60, 1, {2'd0, 2'd0, 2'd0, 2'd3}};
        vecs[6] = '{4'b1011, 8'h70, 3, {2'd0, 2'd3, 2'd1, 2'd0}};

        // Reset and idle
        reset   = 1'b1;
        in_req  = '0;
        in_data = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ack", 32'(in_ack), 32'd0);
        chk("rst_out_req", 32'(out_req), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_grant", 32'(grant), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        toggles = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clk);
            #1;
            if (out_req !== 1'b0 || busy !== 1'b0) toggles++;
        end
        chk("idle_no_activity", 32'(toggles), 32'd0);

        // Single request on input 2
        @(negedge clk);
        in_data[2*SIZE +: SIZE] = 8'hA5;
        in_req[2] = 1'b1;
        @(posedge clk);
        #1;
        chk("single_out_req", 32'(out_req), 32'd1);
        chk("single_grant", 32'(grant), 32'd2);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_busy_c0", 32'(busy), 32'd1);
        @(posedge clk);
        #1;
        chk("single_busy_c1", 32'(busy), 32'd1);
        chk("single_ack_c1", 32'(in_ack), 32'b0000);
        @(posedge clk);
        #1;
        chk("single_busy_c2", 32'(busy), 32'd0);
        chk("single_ack_c2", 32'(in_ack), 32'b0100);

        // Table of simultaneous/rotation vectors from a fresh pointer
        do_reset();
        for (int v = 0; v < 7; v++) run_vec(v);

        // Stalled downstream
        @(negedge clk);
        sink_delay = 10;
        in_data[1*SIZE +: SIZE] = 8'h77;
        prev_ack = in_ack;
        in_req[1] = ~in_req[1];
        @(posedge clk);
        #1;
        chk("stall_grant", 32'(grant), 32'd1);
        chk("stall_busy0", 32'(busy), 32'd1);
        bad = 0;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (busy !== 1'b1 || out_data !== 8'h77 || in_ack !== prev_ack) bad++;
        end
        chk("stall_held", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        chk("stall_done_busy", 32'(busy), 32'd0);
        chk("stall_done_ack", 32'(in_ack), 32'(prev_ack ^ 4'b0010));

        // Reset in the middle of a transfer
        do_reset();
        sink_delay = 10;
        in_data[3*SIZE +: SIZE] = 8'h3C;
        in_req[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_out_req", 32'(out_req), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        chk("mid_grant", 32'(grant), 32'd3);
        #2;
        reset  = 1'b1;
        in_req = '0;
        #1;
        chk("mid_rst_out_req", 32'(out_req), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_grant", 32'(grant), 32'd0);
        chk("mid_rst_data", 32'(out_data), 32'd0);
        chk("mid_rst_in_ack", 32'(in_ack), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset      = 1'b0;
        sink_delay = 1;
        @(negedge clk);
        in_req[3] = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_out_req", 32'(out_req), 32'd1);
        chk("post_rst_grant", 32'(grant), 32'd3);
        chk("post_rst_data", 32'(out_data), 32'h3C);
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_ack", 32'(in_ack), 32'b1000);
        chk("post_rst_busy", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
